// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scheduler: mult/div FSM states,
// stall_reason encoding and the mult/div counter width helper.
package hazard_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_e;

   localparam logic [1:0] NONE     = 2'd0;
   localparam logic [1:0] LOAD_USE = 2'd1;
   localparam logic [1:0] BRANCH   = 2'd2;
   localparam logic [1:0] HILO     = 2'd3;

   // Counter holds at most cycles-1, which always fits in $clog2(cycles) bits.
   function automatic int cnt_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Mult/div sequencer: IDLE/BUSY FSM with a down-counter. busy is high for
// exactly CYCLES cycles following the start pulse.
module muldiv_seq
   import hazard_pkg::*;
#(
   parameter int CYCLES = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy
);

   localparam int            CW   = cnt_width(CYCLES);
   localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

   md_state_e     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (start) begin
            state_nxt = BUSY;
            cnt_nxt   = LOAD;
         end
         BUSY: if (cnt == '0) state_nxt = IDLE;
               else           cnt_nxt   = cnt - CW'(1);
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler: load-use, ID-stage branch operand and HI/LO
// stalls, IF/ID flush on taken control transfers, mult/div issue, stall count.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULDIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs_addr,
   input  logic [4:0]  id_rt_addr,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_is_branch,
   input  logic        id_is_muldiv,
   input  logic        id_reads_hilo,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic        id_ex_MemRead,
   input  logic        id_ex_RegWrite,
   input  logic [4:0]  id_ex_write_addr,
   input  logic        ex_mem_MemRead,
   input  logic [4:0]  ex_mem_write_addr,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        muldiv_start,
   output logic        muldiv_busy,
   output logic [1:0]  stall_reason,
   output logic [31:0] stall_count
);

   logic        lu_hit, br_hit, hl_hit, stall;
   logic [31:0] stall_cnt_q;

   // $zero is never a real dependency.
   function automatic logic src_match(input logic [4:0] a, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic urs,
                                      input logic urt);
      return (a != 5'd0) && ((a == rs && urs) || (a == rt && urt));
   endfunction

   assign lu_hit = id_ex_MemRead &&
                   src_match(id_ex_write_addr, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt);
   assign br_hit = id_is_branch &&
                   ((id_ex_RegWrite &&
                     src_match(id_ex_write_addr, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt)) ||
                    (ex_mem_MemRead &&
                     src_match(ex_mem_write_addr, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt)));
   assign hl_hit = muldiv_busy && (id_is_muldiv || id_reads_hilo);
   assign stall  = reset && (lu_hit || br_hit || hl_hit);

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      muldiv_start = 1'b0;
      stall_reason = NONE;
      if (reset) begin
         if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if      (lu_hit) stall_reason = LOAD_USE;
            else if (br_hit) stall_reason = BRANCH;
            else             stall_reason = HILO;
         end else begin
            if_id_flush  = branch_taken || jump;
            muldiv_start = id_is_muldiv && !muldiv_busy;
         end
      end
   end

   muldiv_seq #(.CYCLES(MULDIV_CYCLES)) u_muldiv_seq (
      .clk   (clk),
      .reset (reset),
      .start (muldiv_start),
      .busy  (muldiv_busy)
   );

   always_ff @(posedge clk) begin
      if (!reset)
         stall_cnt_q <= '0;
      else if (stall && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_count = stall_cnt_q;

endmodule
